ack_pipe_mc: RTL and testbench

- Multi-channel, multi-deep successor to the single-entry ack pipe in the object-processor/bus interface path.
- Each of CHANNELS requesters posts latch requests (latchd pulses). Up to DEPTH requests per channel are counted as outstanding.
- A round-robin grant selects one pending channel at a time. The shared bus ack retires one request of the granted channel and produces that channel's latch strobe.
- Replaces per-channel ack_pipe instances where more than one request can be in flight.

---
 rtl/ack_pipe_mc.sv | 121 ++++++++++++
 tb/tb_ack_pipe_mc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ack_pipe_mc.sv
// ack_pipe_mc: multi-channel, multi-deep ack pipe.
// Each channel counts up to DEPTH outstanding latch requests. A round-robin
// arbiter grants one pending channel at a time. The shared bus ack retires
// one request of the granted channel and pulses that channel's latch strobe.
module ack_pipe_mc #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 3
) (
    input  logic                clk,
    input  logic                resetl,
    input  logic [CHANNELS-1:0] latchd,
    input  logic                ack,
    input  logic                ovf_clr,
    output logic [CHANNELS-1:0] latch,
    output logic [CHANNELS-1:0] gnt,
    output logic                busy,
    output logic [CHANNELS-1:0] ovf
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [PW-1:0] PTR_LAST = PW'(CHANNELS - 1);

    logic [CW-1:0]       cnt   [CHANNELS];
    logic [CW-1:0]       cnt_n [CHANNELS];
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_n;
    logic [CHANNELS-1:0] gnt_n;
    logic [CHANNELS-1:0] ovf_n;
    logic [CHANNELS-1:0] new_ovf;
    logic                busy_n;

    // Strobe is the AND of the registered grant and the live bus ack, so an
    // ack with no grant outstanding has no effect anywhere.
    assign latch = gnt & {CHANNELS{ack}};

    // Per-channel count update and overflow detection.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        new_ovf = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_n[i] = cnt[i];
            if (latchd[i] && !latch[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    new_ovf[i] = 1'b1;       // request dropped
                end else begin
                    cnt_n[i] = cnt[i] + CNT_ONE;
                end
            end else if (latch[i] && !latchd[i] && (cnt[i] != CNT_ZERO)) begin
                cnt_n[i] = cnt[i] - CNT_ONE;
            end
            // Both set: one posted and one retired, count unchanged even at DEPTH.
        end
    end

    // Sticky overflow flags; a new overflow beats a same-cycle clear.
    always_comb begin
        ovf_n = (ovf & {CHANNELS{~ovf_clr}}) | new_ovf;
    end

    // Busy reflects the counts that will hold after this edge.
    always_comb begin
        busy_n = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cnt_n[i] != CNT_ZERO) busy_n = 1'b1;
        end
    end

    // Round-robin re-arbitration when idle or when the granted channel retires.
    // Search starts just past the last winner, so the retired channel is
    // considered last and is re-granted only when it is the sole pender.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        int            pos;
        gnt_n = gnt;
        ptr_n = ptr;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        if ((gnt == '0) || (latch != '0)) begin
            gnt_n = '0;
            for (int k = 1; k <= CHANNELS; k++) begin
                pos = (int'(ptr) + k) % CHANNELS;
                idx = PW'(pos);
                if (!found && (cnt_n[idx] != CNT_ZERO)) begin
                    found      = 1'b1;
                    gnt_n      = '0;
                    gnt_n[idx] = 1'b1;
                    ptr_n      = idx;
                end
            end
        end
    end

    // State registers: counts, grant, pointer, busy and overflow flags.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            // NOTE: the count array is a handful of flops, not a RAM, so it is
            // cleared on reset along with the rest of the state; sequential
            // state uses non-blocking assignments only.
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= CNT_ZERO;
            gnt  <= '0;
            ptr  <= PTR_LAST;
            busy <= 1'b0;
            ovf  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_n[i];
            gnt  <= gnt_n;
            ptr  <= ptr_n;
            busy <= busy_n;
            ovf  <= ovf_n;
        end
    end

endmodule

// File: tb/tb_ack_pipe_mc.sv
// Self-checking bench for ack_pipe_mc: directed scenarios followed by random
// traffic, all compared against an integer-based reference model.
module tb_ack_pipe_mc;

    localparam int CH    = 4;
    localparam int DEPTH = 3;

    logic          clk;
    logic          resetl;
    logic [CH-1:0] latchd;
    logic          ack;
    logic          ovf_clr;
    logic [CH-1:0] latch;
    logic [CH-1:0] gnt;
    logic          busy;
    logic [CH-1:0] ovf;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (plain integers and bit vectors).
    int            m_cnt [CH];
    int            m_ptr;
    logic [CH-1:0] m_gnt;
    logic [CH-1:0] m_ovf;
    logic          m_busy;

    // Values sampled in the most recent cycle, for directed literal checks.
    logic [CH-1:0] s_latch;
    logic [CH-1:0] s_gnt;
    logic          s_busy;
    logic [CH-1:0] s_ovf;

    ack_pipe_mc #(.CHANNELS(CH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetl  (resetl),
        .latchd  (latchd),
        .ack     (ack),
        .ovf_clr (ovf_clr),
        .latch   (latch),
        .gnt     (gnt),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        m_ptr  = CH - 1;
        m_gnt  = '0;
        m_ovf  = '0;
        m_busy = 1'b0;
    endtask

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input logic [CH-1:0] ld, input logic ak, input logic clr);
        logic [CH-1:0] lt;
        logic [CH-1:0] nov;
        lt  = ak ? m_gnt : '0;
        nov = '0;
        for (int i = 0; i < CH; i++) begin
            if (ld[i] && !lt[i]) begin
                if (m_cnt[i] == DEPTH) nov[i] = 1'b1;
                else m_cnt[i] = m_cnt[i] + 1;
            end else if (lt[i] && !ld[i]) begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end
        m_ovf = (clr ? '0 : m_ovf) | nov;
        if ((m_gnt == '0) || (lt != '0)) begin
            m_gnt = '0;
            for (int k = 1; k <= CH; k++) begin
                int j;
                j = (m_ptr + k) % CH;
                if (m_gnt == '0 && m_cnt[j] > 0) begin
                    m_gnt    = '0;
                    m_gnt[j] = 1'b1;
                    m_ptr    = j;
                end
            end
        end
        m_busy = 1'b0;
        for (int i = 0; i < CH; i++) if (m_cnt[i] > 0) m_busy = 1'b1;
    endtask

    // One clock: drive at the falling edge, check mid-low-phase, step at rise.
    task automatic cyc(input logic [CH-1:0] ld, input logic ak, input logic clr);
        @(negedge clk);
        latchd  = ld;
        ack     = ak;
        ovf_clr = clr;
        #1;
        s_latch = latch;
        s_gnt   = gnt;
        s_busy  = busy;
        s_ovf   = ovf;
        check("latch", 32'(latch), 32'(ak ? m_gnt : '0));
        check("gnt",   32'(gnt),   32'(m_gnt));
        check("busy",  32'(busy),  32'(m_busy));
        check("ovf",   32'(ovf),   32'(m_ovf));
        @(posedge clk);
        model_step(ld, ak, clr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetl  = 1'b0;
        latchd  = '0;
        ack     = 1'b0;
        ovf_clr = 1'b0;
        #1;
        model_reset();
        check("rst_gnt",  32'(gnt),  32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ovf",  32'(ovf),  32'(0));
        @(negedge clk);
        resetl = 1'b1;
    endtask

    initial begin
        int ch2_strobes;
        resetl  = 1'b0;
        latchd  = '0;
        ack     = 1'b0;
        ovf_clr = 1'b0;
        model_reset();
        do_reset();

        // Single request, acked on the following cycle.
        cyc(4'b0001, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0);
        check("t1_gnt",   32'(s_gnt),   32'(4'b0001));
        check("t1_latch", 32'(s_latch), 32'(4'b0001));
        cyc(4'b0000, 1'b0, 1'b0);
        check("t1_busy_t2", 32'(s_busy), 32'(0));
        check("t1_gnt_t2",  32'(s_gnt),  32'(0));

        // All four channels at once, acks back to back.
        do_reset();
        cyc(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, 1'b1, 1'b0);
            check("t2_rotate", 32'(s_latch), 32'(4'b0001 << k));
        end
        cyc(4'b0000, 1'b0, 1'b0);
        check("t2_gnt_end",  32'(s_gnt),  32'(0));
        check("t2_busy_end", 32'(s_busy), 32'(0));

        // Fill channel 2 to DEPTH, overflow it, then drain with four acks.
        do_reset();
        for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b0, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("t3_ovf", 32'(s_ovf), 32'(4'b0100));
        ch2_strobes = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(4'b0000, 1'b1, 1'b0);
            if (s_latch[2]) ch2_strobes++;
        end
        check("t3_strobes", 32'(ch2_strobes), 32'(3));

        // Request and ack together on the sole pender keep its grant.
        do_reset();
        cyc(4'b0010, 1'b0, 1'b0);
        cyc(4'b0010, 1'b1, 1'b0);
        check("t4_latch", 32'(s_latch), 32'(4'b0010));
        cyc(4'b0000, 1'b0, 1'b0);
        check("t4_gnt", 32'(s_gnt), 32'(4'b0010));
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("t4_busy", 32'(s_busy), 32'(0));

        // A held grant is not preempted by requests on another channel.
        do_reset();
        cyc(4'b0001, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc((k % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
            check("t5_hold", 32'(s_gnt), 32'(4'b0001));
        end
        cyc(4'b0000, 1'b1, 1'b0);
        cyc(4'b0000, 1'b0, 1'b0);
        check("t5_next", 32'(s_gnt), 32'(4'b1000));

        // Overflow and clear in the same cycle: the new overflow wins.
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0);
        check("t6_ovf_wins", 32'(s_ovf), 32'(4'b1000));
        cyc(4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0);
        check("t6_ovf_clr", 32'(s_ovf), 32'(0));

        // Reset mid-operation with counts 2,1,0,3 and ack high.
        do_reset();
        cyc(4'b1011, 1'b0, 1'b0);
        cyc(4'b1001, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b1000, 1'b0, 1'b0);
        @(negedge clk);
        latchd = '0;
        ack    = 1'b1;
        #1;
        check("t7_pre_latch", 32'(latch), 32'(4'b0001));
        resetl = 1'b0;
        #1;
        check("t7_rst_latch", 32'(latch), 32'(0));
        check("t7_rst_gnt",   32'(gnt),   32'(0));
        check("t7_rst_busy",  32'(busy),  32'(0));
        check("t7_rst_ovf",   32'(ovf),   32'(0));
        model_reset();
        @(negedge clk);
        ack    = 1'b0;
        resetl = 1'b1;
        cyc(4'b1000, 1'b0, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0);
        check("t7_first", 32'(s_gnt), 32'(4'b1000));

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [CH-1:0] ld;
            for (int i = 0; i < CH; i++) ld[i] = ($urandom_range(0, 99) < 30);
            cyc(ld, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
